// File: rtl/mem_bist_pkg.sv
// Shared types for the memory BIST: controller states, march phases, timeout default.
// No logic here; imported by the controller and its address generator.
package mem_bist_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
   typedef enum logic [1:0] {P0, P1, P2, P3} phase_t;

   localparam int TMO_DEFAULT = 4;

   // P0/P1 walk addresses upward and use the true pattern; P2/P3 walk down with ~pat.
   function automatic logic phase_up(input phase_t p);
      return (p == P0) || (p == P1);
   endfunction

   function automatic logic phase_wr(input phase_t p);
      return (p == P0) || (p == P2);
   endfunction

endpackage

// File: rtl/mem_bist_addr_gen.sv
// Loadable up/down address counter with a terminal flag (D-1 going up, 0 going down).
// One-cycle update on load/step; no flow control, steps only when told.
module mem_bist_addr_gen #(
   parameter int D      = 16,
   parameter int addr_w = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [addr_w-1:0] load_val,
   input  logic              step,
   input  logic              up,
   output logic [addr_w-1:0] addr,
   output logic              last
);

   always_ff @(posedge clk) begin
      if (rst)
         addr <= '0;
      else if (load)
         addr <= load_val;
      else if (step)
         addr <= up ? addr + addr_w'(1) : addr - addr_w'(1);
   end

   assign last = up ? (addr == addr_w'(D - 1)) : (addr == '0);

endmodule

// File: rtl/mem_bist.sv
// March-style memory BIST: write pat up, read pat up, write ~pat down, read ~pat down.
// Two cycles per access (ACCESS then WAIT); stalls in WAIT for ready, fails after TMO idle cycles.
module mem_bist
   import mem_bist_pkg::*;
#(
   parameter int W      = 8,
   parameter int D      = 16,
   parameter int addr_w = 4,
   parameter int TMO    = TMO_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [W-1:0]      pat,
   output logic              valid,
   output logic              wrd,
   output logic [addr_w-1:0] addr,
   output logic [W-1:0]      wdata,
   input  logic              ready,
   input  logic [W-1:0]      rdata,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [addr_w-1:0] fail_addr,
   output logic [W-1:0]      fail_data,
   output logic [1:0]        fail_phase,
   output logic              timeout
);

   localparam int TW = $clog2(TMO + 1);

   state_t            state, state_nxt;
   phase_t            phase, phase_nxt;
   logic [W-1:0]      pat_q, pat_nxt;
   logic [TW-1:0]     tcnt, tcnt_nxt;
   logic              valid_nxt, wrd_nxt, busy_nxt, done_nxt, pass_nxt, timeout_nxt;
   logic [W-1:0]      wdata_nxt, fail_data_nxt, expect_val;
   logic [addr_w-1:0] fail_addr_nxt, ag_load_val;
   logic [1:0]        fail_phase_nxt;
   logic              ag_load, ag_step, ag_last, mismatch;

   mem_bist_addr_gen #(.D(D), .addr_w(addr_w)) u_addr_gen (
      .clk      (clk),
      .rst      (rst),
      .load     (ag_load),
      .load_val (ag_load_val),
      .step     (ag_step),
      .up       (phase_up(phase)),
      .addr     (addr),
      .last     (ag_last)
   );

   assign expect_val = (phase == P1) ? pat_q : ~pat_q;
   assign mismatch   = !phase_wr(phase) && (rdata != expect_val);

   always_comb begin
      state_nxt      = state;
      phase_nxt      = phase;
      pat_nxt        = pat_q;
      tcnt_nxt       = tcnt;
      valid_nxt      = 1'b0;
      wrd_nxt        = wrd;
      wdata_nxt      = wdata;
      busy_nxt       = busy;
      done_nxt       = done;
      pass_nxt       = pass;
      timeout_nxt    = timeout;
      fail_addr_nxt  = fail_addr;
      fail_data_nxt  = fail_data;
      fail_phase_nxt = fail_phase;
      ag_load        = 1'b0;
      ag_load_val    = '0;
      ag_step        = 1'b0;

      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt      = ACCESS;
               phase_nxt      = P0;
               pat_nxt        = pat;
               busy_nxt       = 1'b1;
               done_nxt       = 1'b0;
               pass_nxt       = 1'b0;
               timeout_nxt    = 1'b0;
               fail_addr_nxt  = '0;
               fail_data_nxt  = '0;
               fail_phase_nxt = '0;
               ag_load        = 1'b1;
            end
         end
         ACCESS: begin
            state_nxt = WAIT;
            tcnt_nxt  = '0;
         end
         WAIT: begin
            if (ready) begin
               if (mismatch) begin
                  state_nxt      = DONE;
                  busy_nxt       = 1'b0;
                  done_nxt       = 1'b1;
                  pass_nxt       = 1'b0;
                  timeout_nxt    = 1'b0;
                  fail_addr_nxt  = addr;
                  fail_data_nxt  = rdata;
                  fail_phase_nxt = phase;
               end else if (ag_last && phase == P3) begin
                  state_nxt = DONE;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
                  pass_nxt  = 1'b1;
               end else if (ag_last) begin
                  // Next phase restarts at its own end of the array, not by counter wrap.
                  state_nxt   = ACCESS;
                  phase_nxt   = phase_t'(phase + 2'd1);
                  ag_load     = 1'b1;
                  ag_load_val = phase_up(phase_nxt) ? '0 : addr_w'(D - 1);
               end else begin
                  state_nxt = ACCESS;
                  ag_step   = 1'b1;
               end
            end else if (tcnt == TW'(TMO - 1)) begin
               state_nxt      = DONE;
               busy_nxt       = 1'b0;
               done_nxt       = 1'b1;
               pass_nxt       = 1'b0;
               timeout_nxt    = 1'b1;
               fail_addr_nxt  = addr;
               fail_data_nxt  = '0;
               fail_phase_nxt = phase;
            end else begin
               tcnt_nxt = tcnt + TW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (state_nxt == ACCESS) begin
         valid_nxt = 1'b1;
         wrd_nxt   = phase_wr(phase_nxt);
         wdata_nxt = phase_up(phase_nxt) ? pat_nxt : ~pat_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         phase      <= P0;
         pat_q      <= '0;
         tcnt       <= '0;
         valid      <= 1'b0;
         wrd        <= 1'b0;
         wdata      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         timeout    <= 1'b0;
         fail_addr  <= '0;
         fail_data  <= '0;
         fail_phase <= '0;
      end else begin
         state      <= state_nxt;
         phase      <= phase_nxt;
         pat_q      <= pat_nxt;
         tcnt       <= tcnt_nxt;
         valid      <= valid_nxt;
         wrd        <= wrd_nxt;
         wdata      <= wdata_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
         pass       <= pass_nxt;
         timeout    <= timeout_nxt;
         fail_addr  <= fail_addr_nxt;
         fail_data  <= fail_data_nxt;
         fail_phase <= fail_phase_nxt;
      end
   end

endmodule

// File: tb/tb_mem_bist.sv
// Bench for mem_bist: memory model with fault injection, access scoreboard, table-driven runs.
module tb_mem_bist;

   localparam int W = 8, D = 16, AW = 4, TMO = 4;

   logic          clk = 1'b0;
   logic          rst, start;
   logic [W-1:0]  pat;
   logic          valid, wrd, busy, done, pass, timeout;
   logic [AW-1:0] addr, fail_addr;
   logic [W-1:0]  wdata, fail_data;
   logic [1:0]    fail_phase;
   logic          ready = 1'b0;
   logic [W-1:0]  rdata = '0;

   always #5 clk = ~clk;

   mem_bist #(.W(W), .D(D), .addr_w(AW), .TMO(TMO)) dut (
      .clk(clk), .rst(rst), .start(start), .pat(pat),
      .valid(valid), .wrd(wrd), .addr(addr), .wdata(wdata),
      .ready(ready), .rdata(rdata),
      .busy(busy), .done(done), .pass(pass),
      .fail_addr(fail_addr), .fail_data(fail_data), .fail_phase(fail_phase),
      .timeout(timeout)
   );

   int checks = 0, errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Memory model. mode 0: ready one cycle after valid; 1: never ready; 2: ready held high.
   logic [W-1:0] mem [D];
   int           mode = 0;
   int           f_addr = -1;
   logic         f_anyval = 1'b0;
   logic [W-1:0] f_val = '0, f_and = '1;

   always @(posedge clk) begin
      ready <= (mode == 2) ? 1'b1 : (valid && mode == 0);
      if (valid && wrd)
         mem[addr] <= wdata;
      if (valid && !wrd)
         rdata <= (int'(addr) == f_addr && (f_anyval || mem[addr] == f_val))
                  ? (mem[addr] & f_and) : mem[addr];
   end

   typedef struct {
      logic          wr;
      logic [AW-1:0] a;
      logic [W-1:0]  d;
   } acc_t;

   acc_t sb[$];
   acc_t e_acc;
   int   nvalid = 0;

   always @(negedge clk) begin
      if (valid) begin
         nvalid++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL acc_unexpected: valid at addr %0h, expected no access", addr);
         end else begin
            e_acc = sb.pop_front();
            check("acc_wrd", 32'(wrd), 32'(e_acc.wr));
            check("acc_addr", 32'(addr), 32'(e_acc.a));
            if (e_acc.wr)
               check("acc_wdata", 32'(wdata), 32'(e_acc.d));
         end
      end
   end

   typedef struct {
      logic [W-1:0]  pat;
      int            mode;
      int            f_addr;
      logic          f_anyval;
      logic [W-1:0]  f_val;
      logic [W-1:0]  f_and;
      logic          exp_pass;
      logic          exp_to;
      logic [1:0]    exp_phase;
      logic [AW-1:0] exp_addr;
      logic [W-1:0]  exp_data;
      int            exp_edge;
      int            exp_nvalid;
   } vec_t;

   vec_t vecs[5];

   task automatic launch(input logic [W-1:0] p);
      acc_t x;
      sb.delete();
      nvalid = 0;
      for (int ph = 0; ph < 4; ph++)
         for (int i = 0; i < D; i++) begin
            x.wr = (ph % 2 == 0);
            x.a  = (ph < 2) ? AW'(i) : AW'(D - 1 - i);
            x.d  = (ph < 2) ? p : ~p;
            sb.push_back(x);
         end
      @(negedge clk);
      pat   = p;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("launch_busy", 32'(busy), 32'd1);
      check("launch_done", 32'(done), 32'd0);
      check("launch_pass", 32'(pass), 32'd0);
      check("launch_valid", 32'(valid), 32'd1);
      check("launch_addr", 32'(addr), 32'd0);
   endtask

   task automatic wait_done(input vec_t v, input string tag, input int kick_at);
      int  n;
      int  seen_at;
      int  nv;
      seen_at = -1;
      for (n = 1; n <= 400; n++) begin
         @(posedge clk);
         #1;
         if (n == kick_at) begin
            pat   = 8'h3C;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            seen_at = n;
            break;
         end
      end
      start = 1'b0;
      check({tag, "_done_edge"}, 32'(seen_at), 32'(v.exp_edge));
      check({tag, "_pass"}, 32'(pass), 32'(v.exp_pass));
      check({tag, "_timeout"}, 32'(timeout), 32'(v.exp_to));
      check({tag, "_fail_phase"}, 32'(fail_phase), 32'(v.exp_phase));
      check({tag, "_fail_addr"}, 32'(fail_addr), 32'(v.exp_addr));
      check({tag, "_fail_data"}, 32'(fail_data), 32'(v.exp_data));
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_nvalid"}, 32'(nvalid), 32'(v.exp_nvalid));
      nv = nvalid;
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_done_held"}, 32'(done), 32'd1);
      check({tag, "_no_more_access"}, 32'(nvalid), 32'(nv));
   endtask

   task automatic run_vec(input vec_t v, input string tag, input int kick_at);
      @(negedge clk);
      mode     = v.mode;
      f_addr   = v.f_addr;
      f_anyval = v.f_anyval;
      f_val    = v.f_val;
      f_and    = v.f_and;
      launch(v.pat);
      wait_done(v, tag, kick_at);
   endtask

   initial begin
      //           pat    mode faddr any   fval   fand   pass to  ph    addr   data   edge nvalid
      vecs[0] = '{8'hA5, 0,   -1,   1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 2'd0, 4'd0,  8'h00, 128, 64};
      vecs[1] = '{8'hFF, 0,    5,   1'b1, 8'h00, 8'hFE, 1'b0, 1'b0, 2'd1, 4'd5,  8'hFE,  44, 22};
      vecs[2] = '{8'h0F, 0,   15,   1'b0, 8'hF0, 8'hEF, 1'b0, 1'b0, 2'd3, 4'd15, 8'hE0,  98, 49};
      vecs[3] = '{8'h5A, 1,   -1,   1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 2'd0, 4'd0,  8'h00, 1 + TMO, 1};
      vecs[4] = '{8'h3C, 2,   -1,   1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 2'd0, 4'd0,  8'h00, 128, 64};

      rst   = 1'b1;
      start = 1'b0;
      pat   = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_wrd", 32'(wrd), 32'd0);
      check("rst_addr", 32'(addr), 32'd0);
      check("rst_wdata", 32'(wdata), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_pass", 32'(pass), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      check("rst_fail_addr", 32'(fail_addr), 32'd0);
      check("rst_fail_data", 32'(fail_data), 32'd0);
      check("rst_fail_phase", 32'(fail_phase), 32'd0);

      // start coinciding with rst must not launch a run
      @(negedge clk);
      start = 1'b1;
      pat   = 8'h77;
      @(posedge clk);
      #1;
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      @(posedge clk);
      #1;
      check("rststart_busy", 32'(busy), 32'd0);
      check("rststart_valid", 32'(valid), 32'd0);

      for (int i = 0; i < 5; i++)
         run_vec(vecs[i], $sformatf("vec%0d", i), 0);

      // start pulsed mid-run is ignored: same pattern, same timing
      run_vec(vecs[0], "busy_start", 20);

      // reset during P2, then a full clean run
      @(negedge clk);
      mode   = 0;
      f_addr = -1;
      launch(8'hA5);
      repeat (80) @(posedge clk);
      #1;
      check("midrun_busy", 32'(busy), 32'd1);
      check("midrun_in_p2", 32'(wrd), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_valid", 32'(valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_addr", 32'(addr), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      run_vec(vecs[0], "after_rst", 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_bist.md
MEM_BIST -- requirements
Module: mem_bist

Interface
REQ-001 SHALL have parameter W, default 8, memory word width.
REQ-002 SHALL have parameter D, default 16, memory depth in words.
REQ-003 SHALL have parameter addr_w, default 4, address width, with D <= 2**addr_w.
REQ-004 SHALL have parameter TMO, default 4, the maximum number of WAIT cycles without ready.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 start  input  1  one-cycle request to run a test; ignored while busy=1.
REQ-008 pat  input  W  test pattern, sampled on the edge that accepts start.
REQ-009 valid  output  1  memory request strobe (registered).
REQ-010 wrd  output  1  memory write(1)/read(0) select (registered).
REQ-011 addr  output  addr_w  memory address (registered).
REQ-012 wdata  output  W  memory write data (registered).
REQ-013 ready  input  1  memory acknowledge; high in the cycle after memory samples valid=1.
REQ-014 rdata  input  W  memory read data, valid while ready=1 for a read.
REQ-015 busy, done, pass  output  1 each  run in progress / run finished (held) / result.
REQ-016 fail_addr  output  addr_w  address of the first failure.
REQ-017 fail_data  output  W  rdata captured at the first failure.
REQ-018 fail_phase  output  2  phase of the first failure.
REQ-019 timeout  output  1  the failure was a missing ready, not a data mismatch.

Function
REQ-020 Phases SHALL run in this order:
- P0: write pat, ascending 0..D-1
- P1: read and expect pat, ascending
- P2: write ~pat, descending D-1..0
- P3: read and expect ~pat, descending
REQ-021 FSM states SHALL be IDLE, ACCESS, WAIT, DONE.
REQ-022 In IDLE, start=1 SHALL:
- latch pat
- clear done, pass, fail_*, timeout
- set busy=1
- select P0, addr 0
- go to ACCESS
REQ-023 ACCESS SHALL drive valid=1 for exactly one cycle, with wrd/addr/wdata for the current phase, then go to WAIT.
REQ-024 WAIT SHALL drive valid=0 and wait for ready=1; reads SHALL compare rdata with the expected value on that same edge.
REQ-025 On ready with no mismatch, WAIT SHALL advance addr, or phase at the terminal address (D-1 ascending, 0 descending), and return to ACCESS.
REQ-026 On a mismatch, the FSM SHALL stop immediately:
- fail_addr = addr, fail_data = rdata, fail_phase = current phase
- pass=0, timeout=0
- go to DONE
REQ-027 If ready stays 0 for TMO consecutive WAIT cycles, the FSM SHALL fail with timeout=1 and fail_data=0, and go to DONE.
REQ-028 Completing P3 at addr 0 without failure SHALL set pass=1 and go to DONE.
REQ-029 DONE SHALL hold busy=0, done=1 and the results; start SHALL begin a new run exactly as in IDLE.
REQ-030 Each access SHALL take exactly 2 cycles; a passing run SHALL raise done 8*D edges after the start edge (128 for D=16).
REQ-031 Address arithmetic SHALL be modulo 2**addr_w; the phase SHALL change only at the terminal address, never by wrap-around.
REQ-032 A ready=1 seen outside WAIT SHALL be ignored.

Reset
REQ-033 When rst=1 on an edge, the FSM SHALL go to IDLE and all outputs SHALL take these values on that edge, including mid-run:
- valid=0, wrd=0, addr=0, wdata=0
- busy=0, done=0, pass=0, timeout=0
- fail_addr=0, fail_data=0, fail_phase=0
REQ-034 start asserted together with rst SHALL be ignored.

Structure
REQ-035 Package mem_bist_pkg SHALL hold the state enum, the phase enum (P0..P3), and the default TMO constant.
REQ-036 Sub-module mem_bist_addr_gen SHALL provide the loadable up/down address counter with a terminal-count flag.
REQ-037 Expected-value and compare logic SHALL stay in mem_bist.

Verification
REQ-038 Clean run: bench memory model with 1-cycle ready; pat=8'hA5, D=16, start -> done=1 and pass=1 at start+128 edges; 64 valid pulses.
REQ-039 Stuck bit: model forces rdata bit0=0 at address 5; pat=8'hFF -> fail_phase=1, fail_addr=5, fail_data=8'hFE, pass=0.
REQ-040 Descending check: fault only on ~pat reads at address 15, pat=8'h0F -> fail_phase=3, fail_addr=15, first P3 access.
REQ-041 Timeout: model never asserts ready -> timeout=1, fail_phase=0, fail_addr=0, done after 1+TMO cycles in WAIT.
REQ-042 Reset mid-run in P2 -> next cycle valid=0, busy=0, done=0; a new start then passes fully.
REQ-043 start pulsed while busy -> no restart, timing unchanged (done at 128 edges).
